// File: rtl/csr_unit_if.sv
// CSR request/response bus between the CSR decode path and csr_unit.
//   req_valid    request present this cycle
//   req_op       00 read, 01 RW, 10 RS (set bits), 11 RC (clear bits)
//   req_addr     12-bit CSR address
//   req_wdata    operand (rs1 or zero-extended immediate)
//   resp_valid   response to the request sampled at the previous edge
//   resp_rdata   CSR value before the update, 0 when illegal
//   resp_illegal request was rejected, no state changed
interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  resp_valid, resp_rdata, resp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output resp_valid, resp_rdata, resp_illegal
  );
endinterface

// File: rtl/csr_unit.sv
// CSR unit: atomic RW/RS/RC on a bank of scratch CSRs and the 64-bit
// mcycle/minstret counters (with read-only cycle/instret shadows).
// The old value is returned one cycle after the request; illegal
// accesses return 0 with resp_illegal set and change no state.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   retire  one instruction retired this cycle (advances minstret)
//   bus     csr_unit_if slave: request in, response out
// Counter halves are 32 bits wide; XLEN is expected to be >= 32.
module csr_unit #(
  parameter int          XLEN         = 32,
  parameter int          NUM_SCRATCH  = 8,
  parameter logic [11:0] SCRATCH_BASE = 12'h340
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire,
  csr_unit_if.slave   bus
);

  localparam int IW = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } op_e;

  logic [XLEN-1:0] scratch [NUM_SCRATCH];
  logic [63:0]     mcycle;
  logic [63:0]     minstret;

  op_e             op;
  logic [12:0]     offset;
  logic [IW-1:0]   idx;
  logic            in_scratch;
  logic            scratch_hit;
  logic            mapped;
  logic            read_only;
  logic            will_write;
  logic            illegal;
  logic            do_write;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;

  assign op = op_e'(bus.req_op);

  // 13-bit subtraction: addresses below the base wrap to a large value
  // and therefore fail the range compare.
  assign offset     = {1'b0, bus.req_addr} - {1'b0, SCRATCH_BASE};
  assign in_scratch = offset < 13'(NUM_SCRATCH);
  assign idx        = offset[IW-1:0];

  always_comb begin
    old_val     = '0;
    mapped      = 1'b0;
    read_only   = 1'b0;
    scratch_hit = 1'b0;
    case (bus.req_addr)
      12'hB00: begin mapped = 1'b1; old_val = XLEN'(mcycle[31:0]); end
      12'hB80: begin mapped = 1'b1; old_val = XLEN'(mcycle[63:32]); end
      12'hB02: begin mapped = 1'b1; old_val = XLEN'(minstret[31:0]); end
      12'hB82: begin mapped = 1'b1; old_val = XLEN'(minstret[63:32]); end
      12'hC00: begin mapped = 1'b1; read_only = 1'b1; old_val = XLEN'(mcycle[31:0]); end
      12'hC80: begin mapped = 1'b1; read_only = 1'b1; old_val = XLEN'(mcycle[63:32]); end
      12'hC02: begin mapped = 1'b1; read_only = 1'b1; old_val = XLEN'(minstret[31:0]); end
      12'hC82: begin mapped = 1'b1; read_only = 1'b1; old_val = XLEN'(minstret[63:32]); end
      default: begin
        if (in_scratch) begin
          mapped      = 1'b1;
          scratch_hit = 1'b1;
          old_val     = scratch[idx];
        end
      end
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (op)
      OP_RW:   new_val = bus.req_wdata;
      OP_RS:   new_val = old_val | bus.req_wdata;
      OP_RC:   new_val = old_val & ~bus.req_wdata;
      default: new_val = old_val;
    endcase
  end

  // RS/RC with a zero operand is a pure read, even on read-only CSRs.
  assign will_write = (op == OP_RW) || ((op != OP_READ) && (bus.req_wdata != '0));
  assign illegal    = !mapped || (read_only && will_write);
  assign do_write   = bus.req_valid && !illegal && will_write;

  // A write to either half suppresses that cycle's increment entirely,
  // so the untouched half holds and no carry crosses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle <= '0;
    end else if (do_write && bus.req_addr == 12'hB00) begin
      mcycle[31:0] <= new_val[31:0];
    end else if (do_write && bus.req_addr == 12'hB80) begin
      mcycle[63:32] <= new_val[31:0];
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minstret <= '0;
    end else if (do_write && bus.req_addr == 12'hB02) begin
      minstret[31:0] <= new_val[31:0];
    end else if (do_write && bus.req_addr == 12'hB82) begin
      minstret[63:32] <= new_val[31:0];
    end else if (retire) begin
      minstret <= minstret + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        scratch[i] <= '0;
      end
    end else if (do_write && scratch_hit) begin
      scratch[idx] <= new_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.resp_illegal <= 1'b0;
    end else begin
      bus.resp_valid   <= bus.req_valid;
      bus.resp_rdata   <= (bus.req_valid && !illegal) ? old_val : '0;
      bus.resp_illegal <= bus.req_valid && illegal;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios followed by
// randomized requests, all compared against a behavioural model of the
// CSR state (scratch array plus two 64-bit counters).
module tb_csr_unit;

  localparam int          XLEN = 32;
  localparam int          NS   = 8;
  localparam logic [11:0] BASE = 12'h340;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic retire = 1'b0;

  always #5 clk = ~clk;

  csr_unit_if #(.XLEN(XLEN)) bus ();

  csr_unit #(
    .XLEN        (XLEN),
    .NUM_SCRATCH (NS),
    .SCRATCH_BASE(BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .retire(retire),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [31:0] m_scr [NS];
  logic [63:0] m_cyc;
  logic [63:0] m_ins;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
    m_cyc = '0;
    m_ins = '0;
  endtask

  // One request cycle: drive at negedge, check the response after the
  // following posedge, then advance the model by that edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic ret);
    logic [31:0] old;
    logic [31:0] nv;
    logic        mapped, ro, ww, ill, cyc_w, ins_w;
    int          k;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    retire        = ret;

    mapped = 1'b1;
    ro     = 1'b0;
    old    = '0;
    k      = int'(a) - int'(BASE);
    case (a)
      12'hB00, 12'hC00: old = m_cyc[31:0];
      12'hB80, 12'hC80: old = m_cyc[63:32];
      12'hB02, 12'hC02: old = m_ins[31:0];
      12'hB82, 12'hC82: old = m_ins[63:32];
      default: begin
        if (k >= 0 && k < NS) old = m_scr[k];
        else mapped = 1'b0;
      end
    endcase
    if (a[11:10] == 2'b11 && mapped) ro = 1'b1;
    ww  = (op == 2'd1) || (op != 2'd0 && wd != 0);
    ill = !mapped || (ro && ww);
    nv  = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);

    @(posedge clk);
    #1;
    check_val($sformatf("resp_valid a=%h op=%0d", a, op), 64'(bus.resp_valid), 64'(v));
    check_val($sformatf("resp_illegal a=%h op=%0d", a, op), 64'(bus.resp_illegal), 64'(v && ill));
    check_val($sformatf("resp_rdata a=%h op=%0d", a, op), 64'(bus.resp_rdata),
              (v && !ill) ? 64'(old) : 64'd0);

    cyc_w = 1'b0;
    ins_w = 1'b0;
    if (v && !ill && ww) begin
      case (a)
        12'hB00: begin m_cyc[31:0]  = nv; cyc_w = 1'b1; end
        12'hB80: begin m_cyc[63:32] = nv; cyc_w = 1'b1; end
        12'hB02: begin m_ins[31:0]  = nv; ins_w = 1'b1; end
        12'hB82: begin m_ins[63:32] = nv; ins_w = 1'b1; end
        default: m_scr[k] = nv;
      endcase
    end
    if (!cyc_w) m_cyc = m_cyc + 64'd1;
    if (!ins_w && ret) m_ins = m_ins + 64'd1;
  endtask

  // Assert reset while a request is being driven; outputs must clear at once.
  task automatic reset_mid_request();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_addr  = BASE;
    bus.req_wdata = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async_valid", 64'(bus.resp_valid), 64'd0);
    check_val("rst_async_rdata", 64'(bus.resp_rdata), 64'd0);
    check_val("rst_async_illegal", 64'(bus.resp_illegal), 64'd0);
    @(posedge clk);
    #1;
    check_val("rst_hold_valid", 64'(bus.resp_valid), 64'd0);
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    model_reset();
  endtask

  logic [11:0] cnt_addrs [8] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'hC00, 12'hC80, 12'hC02, 12'hC82};

  initial begin
    logic [11:0] a;
    logic [31:0] wd;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_valid", 64'(bus.resp_valid), 64'd0);
    check_val("reset_rdata", 64'(bus.resp_rdata), 64'd0);
    rst_n = 1'b1;

    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b0);
    step(1'b1, 2'd0, 12'hC00, 32'h0, 1'b0);

    // Scratch read-modify-write chain
    step(1'b1, 2'd1, 12'h340, 32'h0000_00F0, 1'b0);
    step(1'b1, 2'd2, 12'h340, 32'h0000_000F, 1'b0);
    step(1'b1, 2'd3, 12'h340, 32'h0000_0030, 1'b0);
    step(1'b1, 2'd0, 12'h340, 32'h0, 1'b0);
    check_val("scratch_final", 64'(bus.resp_rdata), 64'h0000_00CF);

    // Illegal accesses
    step(1'b1, 2'd1, 12'hC00, 32'd5, 1'b0);
    check_val("ro_write_illegal", 64'(bus.resp_illegal), 64'd1);
    step(1'b1, 2'd2, 12'hC00, 32'd0, 1'b0);
    step(1'b1, 2'd0, 12'h7FF, 32'd0, 1'b0);
    check_val("unmapped_illegal", 64'(bus.resp_illegal), 64'd1);

    // Carry from low into high word
    step(1'b1, 2'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 2'd1, 12'hB80, 32'h0, 1'b0);
    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b0);
    step(1'b1, 2'd0, 12'hB80, 32'h0, 1'b0);
    check_val("carry_high", 64'(bus.resp_rdata), 64'd1);

    // High-word write in the cycle the low word would wrap
    step(1'b1, 2'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 2'd1, 12'hB80, 32'd7, 1'b0);
    step(1'b1, 2'd0, 12'hB80, 32'h0, 1'b0);
    check_val("collision_high", 64'(bus.resp_rdata), 64'd7);
    step(1'b1, 2'd0, 12'hB00, 32'h0, 1'b0);

    // minstret
    step(1'b1, 2'd1, 12'hB02, 32'd10, 1'b0);
    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b1);
    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b0);
    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b1);
    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b0);
    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b1);
    step(1'b1, 2'd0, 12'hC02, 32'h0, 1'b0);
    check_val("instret_13", 64'(bus.resp_rdata), 64'd13);
    step(1'b1, 2'd1, 12'hB02, 32'd100, 1'b1);
    step(1'b1, 2'd0, 12'hB02, 32'h0, 1'b0);
    check_val("instret_write_wins", 64'(bus.resp_rdata), 64'd100);

    // Back-to-back write then read
    step(1'b1, 2'd1, 12'h341, 32'hA5A5_1234, 1'b0);
    step(1'b1, 2'd0, 12'h341, 32'h0, 1'b0);
    check_val("b2b_read", 64'(bus.resp_rdata), 64'hA5A5_1234);

    reset_mid_request();
    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b0);
    step(1'b0, 2'd0, 12'h000, 32'h0, 1'b0);
    step(1'b1, 2'd0, 12'hC00, 32'h0, 1'b0);
    check_val("cycle_after_reset", 64'(bus.resp_rdata), 64'd2);
    step(1'b1, 2'd0, 12'h340, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        step(1'b1, 2'd0, BASE, 32'h0, 1'b0);
        reset_mid_request();
      end
      case ($urandom_range(0, 5))
        0, 1:    a = BASE + 12'($urandom_range(0, NS));
        2, 3:    a = cnt_addrs[$urandom_range(0, 7)];
        4:       a = 12'($urandom);
        default: a = BASE - 12'd1;
      endcase
      case ($urandom_range(0, 3))
        0:       wd = 32'h0;
        1:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: wd = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, wd,
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
